// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state
// encodings, Wishbone cycle-type constants and the tenure counter width.
package wb_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'b001,
        ARB_GRANT   = 3'b010,
        ARB_RELEASE = 3'b100
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester at or above
// last_grant+1 (wrapping) as a one-hot grant, plus a valid flag.
module rr_priority_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_grant_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] idx;

    // NUM_MASTERS need not be a power of two, so the wrap is explicit.
    assign start_idx = (last_grant_i == LAST_IDX) ? '0 : last_grant_i + 1'b1;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = start_idx;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS
// masters, with a bounded tenure and a release/idle turnaround between owners.
//
//   state        | meaning
//   ARB_IDLE     | no owner; slave side quiet; arbitrate among m_cyc_i
//   ARB_GRANT    | owner last_grant_q drives the slave port, acks forwarded
//   ARB_RELEASE  | one-cycle turnaround, grant dropped, slave side quiet
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_HOLD      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_gnt_o,
    output logic [ADDRESS_WIDTH-1:0]             adr_o,
    output logic [DATA_WIDTH-1:0]                dat_o,
    output logic                                 we_o,
    output logic [DATA_BYTES-1:0]                sel_o,
    output logic                                 stb_o,
    output logic                                 cyc_o,
    output logic [2:0]                           cti_o,
    input  logic [DATA_WIDTH-1:0]                dat_i,
    input  logic                                 ack_i
);

    localparam int                IDX_W     = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e              state_q, state_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

    logic [NUM_MASTERS-1:0]  pick_gnt;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic                    tenure_end;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i        (m_cyc_i),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick_gnt),
        .valid_o      (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_gnt[i]) pick_idx = IDX_W'(i);
        end
    end

    // The MAX_HOLD-th ack ends the tenure but is still delivered to the owner.
    assign tenure_end = !m_cyc_i[last_grant_q] || (ack_i && hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d      = ARB_GRANT;
                    gnt_d        = pick_gnt;
                    last_grant_d = pick_idx;
                    hold_cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (ack_i && hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
                if (tenure_end) begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            last_grant_q <= LAST_IDX;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign m_gnt_o = gnt_q;
    assign m_dat_o = dat_i;

    // Outside GRANT the slave side is held at zero and acks are swallowed.
    always_comb begin
        adr_o   = '0;
        dat_o   = '0;
        we_o    = 1'b0;
        sel_o   = '0;
        stb_o   = 1'b0;
        cyc_o   = 1'b0;
        cti_o   = CTI_CLASSIC;
        m_ack_o = '0;
        if (state_q == ARB_GRANT) begin
            adr_o   = m_adr_i[last_grant_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            dat_o   = m_dat_i[last_grant_q*DATA_WIDTH +: DATA_WIDTH];
            we_o    = m_we_i[last_grant_q];
            sel_o   = m_sel_i[last_grant_q*DATA_BYTES +: DATA_BYTES];
            stb_o   = m_stb_i[last_grant_q];
            cyc_o   = m_cyc_i[last_grant_q];
            cti_o   = m_cti_i[last_grant_q*3 +: 3];
            m_ack_o[last_grant_q] = ack_i;
        end
    end

endmodule
